// File: rtl/laser_packet_rx_if.sv
// Laser link receive-side bundle: raw serial line in, recovered packet and status out.
// The receiver owns the master modport; the downstream checksum stage uses slave.
`timescale 1ns/1ps
interface laser_packet_rx_if #(
  parameter int PKT_LENGTH = 288
);
  logic                  rx;
  logic [PKT_LENGTH-1:0] data;
  logic                  new_data;
  logic                  busy;
  logic                  frame_err;

  modport master (
    input  rx,
    output data,
    output new_data,
    output busy,
    output frame_err
  );

  modport slave (
    output rx,
    input  data,
    input  new_data,
    input  busy,
    input  frame_err
  );
endinterface

// File: rtl/laser_packet_rx.sv
// Photodiode-side deserializer: recovers one PKT_LENGTH-bit packet per async frame
// (start low, data LSB first, stop high) with mid-bit sampling off a synchronized line.
`timescale 1ns/1ps
module laser_packet_rx #(
  parameter int CLK_PER_BIT = 13540,
  parameter int PKT_LENGTH  = 288,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  laser_packet_rx_if.master bus
);
  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int BIT_W = $clog2(PKT_LENGTH);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(PKT_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_in;
  logic                   rxs;
  logic                   rxs_prev_reg;
  logic                   fall;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [BIT_W-1:0]       bitn_reg, bitn_next;
  logic [PKT_LENGTH-1:0]  shift_reg, shift_next;
  logic [PKT_LENGTH-1:0]  data_reg, data_next;
  logic                   new_data_reg, new_data_next;
  logic                   frame_err_reg, frame_err_next;

  // Synchronizer chain: stage 0 takes the raw line, each later stage the one before it.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_in[gi] = bus.rx;
      end else begin : g_rest
        assign sync_in[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg     <= '1;
      rxs_prev_reg <= 1'b1;
    end else begin
      sync_reg     <= sync_in;
      rxs_prev_reg <= rxs;
    end
  end

  assign rxs  = sync_reg[SYNC_STAGES-1];
  assign fall = rxs_prev_reg & ~rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bitn_reg      <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      new_data_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bitn_reg      <= bitn_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      new_data_reg  <= new_data_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bitn_next      = bitn_reg;
    shift_next     = shift_reg;
    data_next      = data_reg;
    new_data_next  = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fall) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (cnt_reg == HALF_LAST) begin
          if (!rxs) begin
            state_next = DATA;
            cnt_next   = '0;
            bitn_next  = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == FULL_LAST) begin
          shift_next[bitn_reg] = rxs;
          cnt_next             = '0;
          if (bitn_reg == LAST_BIT) begin
            state_next = STOP;
          end else begin
            bitn_next = bitn_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (cnt_reg == FULL_LAST) begin
          cnt_next = '0;
          if (rxs) begin
            data_next     = shift_reg;
            new_data_next = 1'b1;
            state_next    = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_HI;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT_HI: begin
        // A line held low must go high before another start bit is accepted.
        if (rxs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.data      = data_reg;
  assign bus.new_data  = new_data_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_laser_packet_rx.sv
// Directed bench for laser_packet_rx: stimulus pushes expected strobes into a queue,
// an independent negedge monitor pops and checks them as the receiver produces them.
`timescale 1ns/1ps
module tb_laser_packet_rx;
  localparam int    CPB    = 16;
  localparam int    PKT    = 8;
  localparam real   CLK_NS = 10.0;
  localparam real   BIT_NS = CPB * CLK_NS;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];
  int   strobe_q[$];
  bit   nd_prev;

  laser_packet_rx_if #(.PKT_LENGTH(PKT)) bus ();

  laser_packet_rx #(
    .CLK_PER_BIT(CPB),
    .PKT_LENGTH (PKT),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (nd_prev) begin
        n_checks++;
        if (bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_after_new_data: got %b, want 0", bus.busy);
        end
      end
      nd_prev = bus.new_data;
      if (bus.new_data === 1'b1 || bus.frame_err === 1'b1) begin
        strobe_q.push_back(cyc);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: new_data=%b frame_err=%b data=%h, want no strobe",
                   bus.new_data, bus.frame_err, bus.data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus.new_data === bus.frame_err || bus.frame_err !== e.is_err || bus.data !== e.data) begin
            n_fail++;
            $display("FAIL strobe: new_data=%b frame_err=%b data=%h, want frame_err=%b alone data=%h",
                     bus.new_data, bus.frame_err, bus.data, e.is_err, e.data);
          end
        end
      end
    end else begin
      nd_prev = 1'b0;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, want test completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #7;
  endtask

  task automatic expect_pkt(input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [7:0] held);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = held;
    exp_q.push_back(e);
  endtask

  // With stop_low > 0 the stop bit is held low that many periods and left low.
  task automatic send_frame(input logic [7:0] b, input real bit_ns, input int stop_low);
    bus.rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      #(bit_ns);
    end
    if (stop_low > 0) begin
      bus.rx = 1'b0;
      #(bit_ns * stop_low);
    end else begin
      bus.rx = 1'b1;
      #(bit_ns);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((bus.busy !== 1'b0 || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 2000) begin
      n_fail++;
      $display("FAIL %s_timeout: busy=%b pending=%0d, want idle with nothing pending",
               name, bus.busy, exp_q.size());
    end
  endtask

  initial begin
    int busy_cnt;
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    nd_prev  = 1'b0;
    rst_n    = 1'b0;
    bus.rx   = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_data", 32'(bus.data), 32'h00);
    check("reset_new_data", 32'(bus.new_data), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_frame_err", 32'(bus.frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: nominal packet
    expect_pkt(8'hA5);
    $display("tx 8'hA5 nominal");
    align();
    send_frame(8'hA5, BIT_NS, 0);
    wait_idle("t1");
    check("t1_data_held", 32'(bus.data), 32'hA5);

    // 2: short low glitch is rejected in START
    $display("tx 5-clock glitch");
    align();
    bus.rx = 1'b0;
    #(5 * CLK_NS);
    bus.rx = 1'b1;
    busy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cnt++;
    end
    check("t2_busy_seen", 32'(busy_cnt > 0), 32'h1);
    check("t2_busy_le_10", 32'(busy_cnt <= 10), 32'h1);
    check("t2_data_held", 32'(bus.data), 32'hA5);

    // 3: stop bit held low, then a clean packet
    expect_err(8'hA5);
    $display("tx 8'h3C with stop held low 3 periods");
    align();
    send_frame(8'h3C, BIT_NS, 3);
    check("t3_busy_while_low", 32'(bus.busy), 32'h1);
    check("t3_err_reported", 32'(exp_q.size()), 32'h0);
    bus.rx = 1'b1;
    repeat (6) @(negedge clk);
    check("t3_busy_after_rise", 32'(bus.busy), 32'h0);
    check("t3_data_held", 32'(bus.data), 32'hA5);
    #(2 * BIT_NS);
    expect_pkt(8'h01);
    $display("tx 8'h01 after framing error");
    align();
    send_frame(8'h01, BIT_NS, 0);
    wait_idle("t3");

    // 5: reset in the middle of a packet discards it
    $display("tx partial 8'h5A then reset");
    align();
    bus.rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      bus.rx = (i % 2 == 1);
      #(BIT_NS);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_data", 32'(bus.data), 32'h00);
    check("t5_rst_new_data", 32'(bus.new_data), 32'h0);
    check("t5_rst_busy", 32'(bus.busy), 32'h0);
    check("t5_rst_frame_err", 32'(bus.frame_err), 32'h0);
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #(3 * BIT_NS);
    check("t5_no_partial_strobe", 32'(bus.data), 32'h00);
    expect_pkt(8'h5A);
    $display("tx 8'h5A after reset");
    align();
    send_frame(8'h5A, BIT_NS, 0);
    wait_idle("t5");

    // 4: back-to-back frames with no idle gap
    expect_pkt(8'hFF);
    expect_pkt(8'h00);
    $display("tx 8'hFF,8'h00 back-to-back");
    align();
    send_frame(8'hFF, BIT_NS, 0);
    send_frame(8'h00, BIT_NS, 0);
    wait_idle("t4");
    if (strobe_q.size() >= 2)
      check("t4_strobe_spacing", 32'(strobe_q[$] - strobe_q[$-1]), 32'(10 * CPB));
    else
      check("t4_strobe_count", 32'(strobe_q.size()), 32'h2);

    // 6: transmitter period off by about +/-6 percent (17 and 15.04 clocks)
    expect_pkt(8'h96);
    $display("tx 8'h96 at 17-clock bits");
    align();
    send_frame(8'h96, 17.0 * CLK_NS, 0);
    wait_idle("t6_slow");
    expect_pkt(8'h96);
    $display("tx 8'h96 at 15.04-clock bits");
    align();
    send_frame(8'h96, 150.4, 0);
    wait_idle("t6_fast");
    check("t6_data", 32'(bus.data), 32'h96);

    repeat (20) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
